// File: rtl/vedic_product_accumulator_if.sv
// Product-in / result-out handshake bundle for the Vedic product accumulator.
// Latency: none (wires only).
// Backpressure: prod_ready throttles the product stream, res_ready throttles results.
interface vedic_product_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 5
);
    // product stream from the multiplier
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              prod_last;

    // finished-sum stream to the consumer
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [CNT_W-1:0]  res_terms;
    logic              res_ovf;

    // producer of products / consumer of results
    modport master (
        output prod_valid, prod_data, prod_last, res_ready,
        input  prod_ready, res_valid, res_data, res_terms, res_ovf
    );

    // the accumulator itself
    modport slave (
        input  prod_valid, prod_data, prod_last, res_ready,
        output prod_ready, res_valid, res_data, res_terms, res_ovf
    );
endinterface

// File: rtl/vedic_product_accumulator.sv
// Sums a stream of unsigned products per vector (MAC stage); SATURATE_EN selects clamp vs wrap on overflow.
// Latency: result valid one cycle after the closing product; minimum terms+1 cycles per vector.
// Backpressure: prod_ready is dropped while a result is held; the result is held until res_ready.
module vedic_product_accumulator #(
    parameter int PROD_W    = 16,
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 16,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    output logic                         busy,
    vedic_product_accumulator_if.slave   bus
);

    // Configuration sanity: the sum must be wider than one product, and a vector needs a term.
    if (PROD_W >= ACC_W) begin : g_bad_width
        $error("vedic_product_accumulator: PROD_W must be smaller than ACC_W");
    end
    if (MAX_TERMS < 1) begin : g_bad_terms
        $error("vedic_product_accumulator: MAX_TERMS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // running vector state
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    // presented result and registered handshake outputs
    logic [ACC_W-1:0] res_data_q;
    logic [CNT_W-1:0] res_terms_q;
    logic             res_ovf_q;
    logic             res_valid_q;
    logic             prod_ready_q;

    // combinational next values
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_add;
    logic [CNT_W-1:0] cnt_add;
    logic             ovf_add;
    logic             xfer;
    logic             close;
    logic             accept;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_d;
    logic             load_res;

    // Adder path: one extra bit catches the carry out of the accumulator width.
    always_comb begin
        sum     = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_data};
        ovf_add = ovf | sum[ACC_W];
`ifdef SATURATE_EN
        // once the vector has overflowed it stays pinned at full scale
        acc_add = ovf_add ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_add = sum[ACC_W-1:0];
`endif
        cnt_add = cnt + CNT_W'(1);
    end

    // Handshake qualifiers; a product offered during clear is never counted.
    always_comb begin
        xfer   = bus.prod_valid && prod_ready_q && !clear;
        close  = xfer && (bus.prod_last || (cnt_add == CNT_W'(MAX_TERMS)));
        accept = res_valid_q && bus.res_ready;
    end

    // Controller next-state and datapath load decisions; clear overrides everything.
    always_comb begin
        state_next = state;
        acc_d      = acc;
        cnt_d      = cnt;
        ovf_d      = ovf;
        load_res   = 1'b0;

        case (state)
            IDLE, ACCUM: begin
                if (close) begin
                    // the result registers take the sum; the running state restarts empty
                    state_next = HOLD;
                    load_res   = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                end else if (xfer) begin
                    state_next = ACCUM;
                    acc_d      = acc_add;
                    cnt_d      = cnt_add;
                    ovf_d      = ovf_add;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (clear) begin
            state_next = IDLE;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            load_res   = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Running sum, term counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_d;
            cnt <= cnt_d;
            ovf <= ovf_d;
        end
    end

    // Result capture; the fields keep their last value while no result is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q  <= '0;
            res_terms_q <= '0;
            res_ovf_q   <= 1'b0;
        end else if (load_res) begin
            res_data_q  <= acc_add;
            res_terms_q <= cnt_add;
            res_ovf_q   <= ovf_add;
        end
    end

    // Registered handshake outputs follow the next state, so HOLD entry drops prod_ready
    // on the same edge that raises res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            prod_ready_q <= 1'b0;
        end else begin
            res_valid_q  <= (state_next == HOLD);
            prod_ready_q <= (state_next != HOLD);
        end
    end

    assign bus.prod_ready = prod_ready_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_terms  = res_terms_q;
    assign bus.res_ovf    = res_ovf_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_vedic_product_accumulator.sv
// Directed bench for vedic_product_accumulator: a 24-bit instance and a 17-bit overflow instance.
// Expected results are queued at stimulus time and popped when each result is handed off.
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_vedic_product_accumulator;

    localparam int PW   = 16;
    localparam int AW_A = 24;
    localparam int AW_B = 17;
    localparam int MT   = 16;
    localparam int CW   = $clog2(MT + 1);

`ifdef SATURATE_EN
    localparam logic [31:0] T4_DATA = 32'h1FFFF;
`else
    localparam logic [31:0] T4_DATA = 32'h00000;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] terms;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clear_a;
    logic clear_b;
    logic busy_a;
    logic busy_b;

    int passed = 0;
    int total  = 0;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    vedic_product_accumulator_if #(.PROD_W(PW), .ACC_W(AW_A), .CNT_W(CW)) ia ();
    vedic_product_accumulator_if #(.PROD_W(PW), .ACC_W(AW_B), .CNT_W(CW)) ib ();

    vedic_product_accumulator #(.PROD_W(PW), .ACC_W(AW_A), .MAX_TERMS(MT)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_a),
        .busy  (busy_a),
        .bus   (ia.slave)
    );

    vedic_product_accumulator #(.PROD_W(PW), .ACC_W(AW_B), .MAX_TERMS(MT)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_b),
        .busy  (busy_b),
        .bus   (ib.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for instance A: every handed-off result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ia.res_valid === 1'b1 && ia.res_ready === 1'b1) begin
            chk("a_result_expected", 32'(qa.size() > 0), 32'd1);
            if (qa.size() > 0) begin
                exp_t e;
                e = qa.pop_front();
                chk("a_res_data", 32'(ia.res_data), e.data);
                chk("a_res_terms", 32'(ia.res_terms), e.terms);
                chk("a_res_ovf", 32'(ia.res_ovf), 32'(e.ovf));
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ib.res_valid === 1'b1 && ib.res_ready === 1'b1) begin
            chk("b_result_expected", 32'(qb.size() > 0), 32'd1);
            if (qb.size() > 0) begin
                exp_t e;
                e = qb.pop_front();
                chk("b_res_data", 32'(ib.res_data), e.data);
                chk("b_res_terms", 32'(ib.res_terms), e.terms);
                chk("b_res_ovf", 32'(ib.res_ovf), 32'(e.ovf));
            end
        end
    end

    // Offer one product to A; it transfers on the first rising edge with prod_ready high.
    task automatic send_a(input logic [15:0] d, input logic last);
        int n;
        ia.prod_valid = 1'b1;
        ia.prod_data  = d;
        ia.prod_last  = last;
        @(negedge clk);
        n = 0;
        while (ia.prod_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("a_send_ready", 32'(ia.prod_ready), 32'd1);
        @(posedge clk);
        #1;
        ia.prod_valid = 1'b0;
        ia.prod_last  = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d, input logic last);
        int n;
        ib.prod_valid = 1'b1;
        ib.prod_data  = d;
        ib.prod_last  = last;
        @(negedge clk);
        n = 0;
        while (ib.prod_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("b_send_ready", 32'(ib.prod_ready), 32'd1);
        @(posedge clk);
        #1;
        ib.prod_valid = 1'b0;
        ib.prod_last  = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        clear_a       = 1'b0;
        clear_b       = 1'b0;
        ia.prod_valid = 1'b0;
        ia.prod_data  = '0;
        ia.prod_last  = 1'b0;
        ia.res_ready  = 1'b1;
        ib.prod_valid = 1'b0;
        ib.prod_data  = '0;
        ib.prod_last  = 1'b0;
        ib.res_ready  = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", 32'(ia.res_valid), 32'd0);
        chk("rst_res_data", 32'(ia.res_data), 32'd0);
        chk("rst_res_terms", 32'(ia.res_terms), 32'd0);
        chk("rst_res_ovf", 32'(ia.res_ovf), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_prod_ready", 32'(ia.prod_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_prod_ready_low", 32'(ia.prod_ready), 32'd0);
        @(negedge clk);
        chk("rel_prod_ready_high", 32'(ia.prod_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: short vector closed by last
        qa.push_back('{data: 32'h9, terms: 32'd3, ovf: 1'b0});
        send_a(16'h0002, 1'b0);
        send_a(16'h0003, 1'b0);
        send_a(16'h0004, 1'b1);
        @(negedge clk);
        chk("t1_res_valid", 32'(ia.res_valid), 32'd1);
        chk("t1_prod_ready_hold", 32'(ia.prod_ready), 32'd0);
        chk("t1_busy_hold", 32'(busy_a), 32'd1);
        @(negedge clk);
        chk("t1_idle_res_valid", 32'(ia.res_valid), 32'd0);
        chk("t1_idle_busy", 32'(busy_a), 32'd0);
        chk("t1_idle_prod_ready", 32'(ia.prod_ready), 32'd1);
        @(posedge clk);
        #1;

        // 2: auto-close at MAX_TERMS
        qa.push_back('{data: 32'h0FFFF0, terms: 32'd16, ovf: 1'b0});
        for (int i = 0; i < MT; i++) begin
            send_a(16'hFFFF, 1'b0);
            if (i == MT - 2) begin
                chk("t2_open_res_valid", 32'(ia.res_valid), 32'd0);
                chk("t2_open_busy", 32'(busy_a), 32'd1);
            end
        end
        @(negedge clk);
        chk("t2_res_valid", 32'(ia.res_valid), 32'd1);
        @(negedge clk);
        chk("t2_idle_busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1;

        // 3: result held under backpressure
        ia.res_ready = 1'b0;
        qa.push_back('{data: 32'h1234, terms: 32'd1, ovf: 1'b0});
        send_a(16'h1234, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_res_valid", 32'(ia.res_valid), 32'd1);
            chk("t3_hold_res_data", 32'(ia.res_data), 32'h1234);
            chk("t3_hold_prod_ready", 32'(ia.prod_ready), 32'd0);
            chk("t3_hold_busy", 32'(busy_a), 32'd1);
        end
        @(posedge clk);
        #1 ia.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_idle_busy", 32'(busy_a), 32'd0);
        chk("t3_idle_res_valid", 32'(ia.res_valid), 32'd0);
        chk("t3_idle_prod_ready", 32'(ia.prod_ready), 32'd1);
        @(posedge clk);
        #1;

        // 4: overflow in the 17-bit instance
        qb.push_back('{data: T4_DATA, terms: 32'd3, ovf: 1'b1});
        send_b(16'hFFFF, 1'b0);
        send_b(16'hFFFF, 1'b0);
        send_b(16'h0002, 1'b1);
        @(negedge clk);
        chk("t4_res_valid", 32'(ib.res_valid), 32'd1);
        @(negedge clk);
        chk("t4_idle_busy", 32'(busy_b), 32'd0);
        @(posedge clk);
        #1;

        // 5: clear mid-vector; the product offered with clear is dropped
        send_a(16'h0010, 1'b0);
        send_a(16'h0020, 1'b0);
        clear_a       = 1'b1;
        ia.prod_valid = 1'b1;
        ia.prod_data  = 16'h0099;
        ia.prod_last  = 1'b1;
        @(posedge clk);
        #1;
        clear_a       = 1'b0;
        ia.prod_valid = 1'b0;
        ia.prod_last  = 1'b0;
        @(negedge clk);
        chk("t5_clear_busy", 32'(busy_a), 32'd0);
        chk("t5_clear_res_valid", 32'(ia.res_valid), 32'd0);
        chk("t5_clear_prod_ready", 32'(ia.prod_ready), 32'd1);
        @(posedge clk);
        #1;
        qa.push_back('{data: 32'h5, terms: 32'd1, ovf: 1'b0});
        send_a(16'h0005, 1'b1);
        @(negedge clk);
        chk("t5_res_valid", 32'(ia.res_valid), 32'd1);
        @(posedge clk);
        #1;

        // 5b: clear discards a pending result
        ia.res_ready = 1'b0;
        send_a(16'h0007, 1'b1);
        @(negedge clk);
        chk("t5b_hold_res_valid", 32'(ia.res_valid), 32'd1);
        @(posedge clk);
        #1 clear_a = 1'b1;
        @(posedge clk);
        #1;
        clear_a      = 1'b0;
        ia.res_ready = 1'b1;
        @(negedge clk);
        chk("t5b_discard_res_valid", 32'(ia.res_valid), 32'd0);
        chk("t5b_discard_busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1;

        // 6: asynchronous reset while holding a result
        ia.res_ready = 1'b0;
        send_a(16'h0055, 1'b1);
        @(negedge clk);
        chk("t6_hold_res_valid", 32'(ia.res_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_res_valid", 32'(ia.res_valid), 32'd0);
        chk("t6_rst_res_data", 32'(ia.res_data), 32'd0);
        chk("t6_rst_res_terms", 32'(ia.res_terms), 32'd0);
        chk("t6_rst_res_ovf", 32'(ia.res_ovf), 32'd0);
        chk("t6_rst_busy", 32'(busy_a), 32'd0);
        chk("t6_rst_prod_ready", 32'(ia.prod_ready), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("t6_rel_prod_ready_low", 32'(ia.prod_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t6_rel_prod_ready_high", 32'(ia.prod_ready), 32'd1);
        ia.res_ready = 1'b1;
        qa.push_back('{data: 32'h11, terms: 32'd1, ovf: 1'b0});
        send_a(16'h0011, 1'b1);
        @(negedge clk);
        chk("t6_res_valid", 32'(ia.res_valid), 32'd1);
        repeat (3) @(negedge clk);

        // every queued expectation must have been consumed
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
